// File: rtl/ntt_pkg.sv
// Shared NTT PE types and modular helpers; helpers work on a widened operand
// (PE_MAX_W+2 bits) so one definition serves any DATA_W up to PE_MAX_W.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif

package ntt_pkg;

  localparam int PE_MAX_W = 32;
  typedef logic [PE_MAX_W+1:0] pe_wide_t;

  typedef enum logic [1:0] {
    CT      = 2'd0,
    GS      = 2'd1,
    GS_HALF = 2'd2,
    ADDSUB  = 2'd3
  } pe_mode_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    POST = 2'd2,
    HOLD = 2'd3
  } pe_state_t;

  function automatic pe_wide_t mod_add(input pe_wide_t a, input pe_wide_t b, input pe_wide_t m);
    pe_wide_t s;
    s = a + b;
    if (s >= m) s = s - m;
    return s;
  endfunction

  // Operands are already reduced, so a single +m restores the range.
  function automatic pe_wide_t mod_sub(input pe_wide_t a, input pe_wide_t b, input pe_wide_t m);
    if (a >= b) return a - b;
    return a + m - b;
  endfunction

  function automatic pe_wide_t mod_half(input pe_wide_t x, input pe_wide_t m);
    if (x[0]) return (x + m) >> 1;
    return x >> 1;
  endfunction

endpackage

// File: rtl/ntt_butterfly_pe_mul.sv
// Bit-serial interleaved modular multiplier, MSB first, one bit per cycle after start.
// Operands and modulus must stay stable until last_o; last_o marks the final step.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif

module mod_mul_serial
  import ntt_pkg::*;
#(
  parameter int DATA_W = `DATA_SIZE_ARB
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  input  logic [DATA_W-1:0] q_i,
  output logic              last_o,
  output logic [DATA_W-1:0] prod_o
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic              run_q, run_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  pe_wide_t          dbl_w, step_w;
  logic              unused_ok;

  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    // Doubling is add(acc,acc): one conditional subtraction, then one more for +a.
    dbl_w  = mod_add(pe_wide_t'(acc_q), pe_wide_t'(acc_q), pe_wide_t'(q_i));
    step_w = b_i[cnt_q] ? mod_add(dbl_w, pe_wide_t'(a_i), pe_wide_t'(q_i)) : dbl_w;
    if (start) begin
      run_d = 1'b1;
      cnt_d = CNT_W'(DATA_W - 1);
      acc_d = '0;
    end else if (run_q) begin
      acc_d = step_w[DATA_W-1:0];
      if (cnt_q == '0) run_d = 1'b0;
      else             cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  assign last_o    = run_q && (cnt_q == '0);
  assign prod_o    = acc_q;
  assign unused_ok = ^{dbl_w[PE_MAX_W+1:DATA_W], step_w[PE_MAX_W+1:DATA_W]};

endmodule

// File: rtl/ntt_butterfly_pe.sv
// NTT butterfly PE (CT / GS / GS-halving / add-sub); result DATA_W+1 edges after accept
// (1 for add-sub). Results held until out_ready; one butterfly in flight, in_ready only in IDLE.
`ifndef DATA_SIZE_ARB
`define DATA_SIZE_ARB 16
`endif

module ntt_butterfly_pe
  import ntt_pkg::*;
#(
  parameter int DATA_W = `DATA_SIZE_ARB
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] q,
  input  logic [DATA_W-1:0] w,
  input  logic [DATA_W-1:0] data_top_i,
  input  logic [DATA_W-1:0] data_bot_i,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ntt_top_o,
  output logic [DATA_W-1:0] ntt_bot_o,
  output logic              busy
);

  pe_state_t         state_q, state_d;
  pe_mode_t          mode_q, mode_d;
  logic [DATA_W-1:0] q_q, q_d, w_q, w_d, top_q, top_d, bot_q, bot_d;
  logic [DATA_W-1:0] sum_q, sum_d, diff_q, diff_d;
  logic [DATA_W-1:0] top_o_q, top_o_d, bot_o_q, bot_o_d;
  logic              out_valid_q, out_valid_d;

  logic              mul_start, mul_last;
  logic [DATA_W-1:0] prod;
  pe_wide_t          sum_w, diff_w, res_t_w, res_b_w;
  logic              unused_ok;

  assign mul_start = (state_q == IDLE) && in_valid && (pe_mode_t'(mode) != ADDSUB);

  // Multiplier reads the captured operands, which are frozen for the whole MUL phase.
  mod_mul_serial #(.DATA_W(DATA_W)) u_mul (
    .clk    (clk),
    .rst_n  (reset),
    .start  (mul_start),
    .a_i    (w_q),
    .b_i    ((mode_q == CT) ? bot_q : diff_q),
    .q_i    (q_q),
    .last_o (mul_last),
    .prod_o (prod)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    q_d         = q_q;
    w_d         = w_q;
    top_d       = top_q;
    bot_d       = bot_q;
    sum_d       = sum_q;
    diff_d      = diff_q;
    top_o_d     = top_o_q;
    bot_o_d     = bot_o_q;
    out_valid_d = out_valid_q;
    sum_w       = mod_add(pe_wide_t'(data_top_i), pe_wide_t'(data_bot_i), pe_wide_t'(q));
    diff_w      = mod_sub(pe_wide_t'(data_top_i), pe_wide_t'(data_bot_i), pe_wide_t'(q));

    case (mode_q)
      CT: begin
        res_t_w = mod_add(pe_wide_t'(top_q), pe_wide_t'(prod), pe_wide_t'(q_q));
        res_b_w = mod_sub(pe_wide_t'(top_q), pe_wide_t'(prod), pe_wide_t'(q_q));
      end
      GS: begin
        res_t_w = pe_wide_t'(sum_q);
        res_b_w = pe_wide_t'(prod);
      end
      GS_HALF: begin
        res_t_w = mod_half(pe_wide_t'(sum_q), pe_wide_t'(q_q));
        res_b_w = mod_half(pe_wide_t'(prod), pe_wide_t'(q_q));
      end
      default: begin
        res_t_w = pe_wide_t'(sum_q);
        res_b_w = pe_wide_t'(diff_q);
      end
    endcase

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          mode_d  = pe_mode_t'(mode);
          q_d     = q;
          w_d     = w;
          top_d   = data_top_i;
          bot_d   = data_bot_i;
          sum_d   = sum_w[DATA_W-1:0];
          diff_d  = diff_w[DATA_W-1:0];
          state_d = (pe_mode_t'(mode) == ADDSUB) ? POST : MUL;
        end
      end
      MUL: begin
        if (mul_last) state_d = POST;
      end
      POST: begin
        top_o_d     = res_t_w[DATA_W-1:0];
        bot_o_d     = res_b_w[DATA_W-1:0];
        out_valid_d = 1'b1;
        state_d     = HOLD;
      end
      default: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mode_q      <= CT;
      q_q         <= '0;
      w_q         <= '0;
      top_q       <= '0;
      bot_q       <= '0;
      sum_q       <= '0;
      diff_q      <= '0;
      top_o_q     <= '0;
      bot_o_q     <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      q_q         <= q_d;
      w_q         <= w_d;
      top_q       <= top_d;
      bot_q       <= bot_d;
      sum_q       <= sum_d;
      diff_q      <= diff_d;
      top_o_q     <= top_o_d;
      bot_o_q     <= bot_o_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = reset && (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = out_valid_q;
  assign ntt_top_o = top_o_q;
  assign ntt_bot_o = bot_o_q;
  assign unused_ok = ^{sum_w[PE_MAX_W+1:DATA_W], diff_w[PE_MAX_W+1:DATA_W],
                       res_t_w[PE_MAX_W+1:DATA_W], res_b_w[PE_MAX_W+1:DATA_W]};

endmodule

// File: tb/tb_ntt_butterfly_pe.sv
// Directed bench for ntt_butterfly_pe at DATA_W=16, q=7681 with hand-computed results.
module tb_ntt_butterfly_pe;

  localparam int DATA_W = 16;
  localparam int QV     = 7681;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        mode;
  logic [DATA_W-1:0] q;
  logic [DATA_W-1:0] w;
  logic [DATA_W-1:0] data_top_i;
  logic [DATA_W-1:0] data_bot_i;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] ntt_top_o;
  logic [DATA_W-1:0] ntt_bot_o;
  logic              busy;

  int n_checks = 0;
  int n_fails  = 0;

  ntt_butterfly_pe #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mode       (mode),
    .q          (q),
    .w          (w),
    .data_top_i (data_top_i),
    .data_bot_i (data_bot_i),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ntt_top_o  (ntt_top_o),
    .ntt_bot_o  (ntt_bot_o),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Issue one butterfly, scramble inputs after acceptance, wait (bounded) for out_valid.
  task automatic run_op(input string tag, input logic [1:0] m, input int t, input int b,
                        input int ww, input int exp_t, input int exp_b, input int exp_lat);
    int lat;
    @(negedge clk);
    chk({tag, "_in_ready"}, in_ready, 1);
    mode       = m;
    q          = DATA_W'(QV);
    w          = DATA_W'(ww);
    data_top_i = DATA_W'(t);
    data_bot_i = DATA_W'(b);
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid   = 1'b0;
    mode       = 2'd3 - m;
    w          = 16'd1234;
    data_top_i = 16'd4321;
    data_bot_i = 16'd999;
    chk({tag, "_busy"}, busy, 1);
    lat = 0;
    for (int k = 1; k <= 64; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_top"}, ntt_top_o, exp_t);
    chk({tag, "_bot"}, ntt_bot_o, exp_b);
  endtask

  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk({tag, "_vld_clr"}, out_valid, 0);
    chk({tag, "_rdy_back"}, in_ready, 1);
    chk({tag, "_idle"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    mode       = 2'd0;
    q          = DATA_W'(QV);
    w          = '0;
    data_top_i = '0;
    data_bot_i = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_top", ntt_top_o, 0);
    chk("rst_bot", ntt_bot_o, 0);
    chk("rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b1;

    run_op("ct", 2'd0, 100, 200, 3, 700, 7181, 17);
    drain("ct");
    run_op("gs", 2'd1, 7000, 1000, 2, 319, 4319, 17);
    drain("gs");
    run_op("gsh", 2'd2, 7000, 1000, 2, 4000, 6000, 17);
    drain("gsh");
    run_op("addsub", 2'd3, 7680, 1, 0, 0, 7679, 1);
    drain("addsub");

    // Back-pressure: results frozen, a fresh request is ignored while held.
    run_op("bp", 2'd0, 100, 200, 3, 700, 7181, 17);
    mode       = 2'd3;
    data_top_i = 16'd5;
    data_bot_i = 16'd6;
    in_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("bp_vld_hold", out_valid, 1);
      chk("bp_top_hold", ntt_top_o, 700);
      chk("bp_bot_hold", ntt_bot_o, 7181);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    drain("bp");

    // Reset in the middle of the multiply phase.
    @(negedge clk);
    chk("mrst_start_rdy", in_ready, 1);
    mode       = 2'd0;
    data_top_i = 16'd100;
    data_bot_i = 16'd200;
    w          = 16'd3;
    in_valid   = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("mrst_out_valid", out_valid, 0);
    chk("mrst_top", ntt_top_o, 0);
    chk("mrst_bot", ntt_bot_o, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_in_ready_low", in_ready, 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_in_ready_high", in_ready, 1);

    run_op("after_rst", 2'd0, 1, 1, 1, 2, 0, 17);
    drain("after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/ntt_butterfly_pe.md
# ntt_butterfly_pe

Parametrised, handshaked NTT butterfly processing element, the successor to the combinational modular add/sub PE. It supports forward Cooley-Tukey and inverse Gentleman-Sande butterflies with a twiddle multiply and optional inverse-halving, plus a plain add/sub mode. The twiddle product uses a bit-serial interleaved modular multiplier, one bit per cycle. It sits between the coefficient memory read/write ports of the NTT datapath and processes one butterfly at a time.

## Interface
- `DATA_W`, default `` `DATA_SIZE_ARB ``, coefficient/modulus width in bits.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand set present.
- `in_ready`  out  1  PE can accept; high only in IDLE, low while `reset` is asserted.
- `mode`  in  2  0 CT, 1 GS, 2 GS with halving, 3 add/sub only.
- `q`  in  DATA_W  modulus; odd, ≥3, below 2^(DATA_W-1).
- `w`  in  DATA_W  twiddle, < q; ignored in mode 3.
- `data_top_i`, `data_bot_i`  in  DATA_W  operands, each < q.
- `out_valid`  out  1  results valid.
- `out_ready`  in  1  consumer accepts results.
- `ntt_top_o`, `ntt_bot_o`  out  DATA_W  results, each < q.
- `busy`  out  1  state ≠ IDLE.

## Operation
- All arithmetic is mod q. add(a,b) = a+b, minus q if ≥ q. sub(a,b) = a−b, plus q if negative. Intermediates are DATA_W+2 bits signed.
- Mode 0 (CT): m = w·bot; top_o = add(top,m); bot_o = sub(top,m).
- Mode 1 (GS): top_o = add(top,bot); bot_o = w·sub(top,bot).
- Mode 2 (GS/2): as mode 1, then each output is halved: x even → x>>1; x odd → (x+q)>>1.
- Mode 3: top_o = add(top,bot); bot_o = sub(top,bot); no multiply.
- Multiply is interleaved: acc=0; for i=DATA_W−1..0: acc=2·acc mod q; if b[i], acc=add(acc,a). There is one bit step per cycle, each step using at most two conditional subtractions. In CT, a=w and b=bot. In GS, a=w and b=the captured difference.
- State machine:
  - IDLE → CAPT on in_valid & in_ready. The capture edge registers q, w, mode, top, bot, and the GS sum and difference.
  - CAPT is folded into the acceptance edge: the next state is MUL for modes 0–2 and POST for mode 3.
  - MUL runs for exactly DATA_W cycles (bit counter DATA_W−1 → 0), then goes to POST.
  - POST takes one cycle: it computes the final add/sub/halving, registers the outputs and sets out_valid, then goes to HOLD.
  - HOLD → IDLE on out_ready. out_valid is cleared on that edge.
- Input changes after acceptance have no effect on the operation in flight.

## Timing
- Reset (asynchronous assert) forces: state IDLE, out_valid 0, ntt_top_o/ntt_bot_o 0, bit counter 0, accumulator 0, busy 0.
- Reset asserted mid-operation aborts the operation and drops out_valid immediately. No result is produced.
- Latency, counting the acceptance edge as edge 0:
  - modes 0–2: out_valid is high after edge DATA_W+1;
  - mode 3: out_valid is high after edge 1.
- Outputs hold stable while out_valid & !out_ready.
- in_ready returns high in the cycle after the out handshake edge. Minimum issue interval is DATA_W+3 cycles (modes 0–2) and 3 cycles (mode 3).
- in_valid asserted while in_ready is low is ignored. The source must hold its operands until in_ready is high.

## Structure
- Shared package `ntt_pkg` holds:
  - the `pe_mode_t` enum (CT, GS, GS_HALF, ADDSUB);
  - the `pe_state_t` enum (IDLE, MUL, POST, HOLD);
  - `mod_add`/`mod_sub`/`mod_half` functions parameterised on width.
- Sub-module `mod_mul_serial` contains the interleaved multiplier with its bit counter and accumulator, under start/done control. The top level owns the FSM, the handshake and the post-processing.

## Test plan
- DATA_W=16, q=7681, mode 0, top=100, bot=200, w=3 → top_o=700, bot_o=7181; out_valid first high after edge 17.
- Mode 1, top=7000, bot=1000, w=2 → top_o=319, bot_o=4319.
- Mode 2 with the same operands → top_o=4000, bot_o=6000.
- Mode 3, top=7680, bot=1 → top_o=0, bot_o=7679; out_valid after edge 1.
- Back-pressure: hold out_ready low for 5 cycles after out_valid → outputs and out_valid stable, in_ready low, a new in_valid ignored; in_ready high one cycle after release.
- Reset at MUL cycle 8 → out_valid 0, outputs 0, in_ready high after release. The next butterfly (mode 0, 1,1,w=1 → 2,0) is correct.
